// File: rtl/pgpmem_rdunpack_pkg.sv
// pgpmem_rdunpack_pkg: weight-memory element types and unpacker FSM states
package pgpmem_rdunpack_pkg;
  localparam int WEIGHTMEM_CLK_DIV = 2;
  typedef logic [15:0] PGP;
  typedef logic [WEIGHTMEM_CLK_DIV*16-1:0] PGP2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/pgpmem_rdunpack_fifo.sv
// pgpmem_rdunpack_fifo: small FIFO with combinational head and occupancy count
module pgpmem_rdunpack_fifo #(
  parameter type Q = logic,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  Q                         d,
  input  logic                     rd,
  output Q                         q,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  Q mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic wr_en, rd_en;
  assign empty = count == '0;
  assign wr_en = wr & (count != (PW+1)'(DEPTH));
  assign rd_en = rd & !empty;
  assign q = mem[rp];
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= d;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp == PW'(DEPTH-1) ? '0 : wp + PW'(1);
      if (rd_en) rp <= rp == PW'(DEPTH-1) ? '0 : rp + PW'(1);
      count <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/pgpmem_rdunpack.sv
// pgpmem_rdunpack: bursts wide-word SPRAM reads and unpacks them into a PGP element stream
module pgpmem_rdunpack
  import pgpmem_rdunpack_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int RDLAT = 2,
  parameter int BUFDEPTH = 16
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [$clog2(DEPTH)-1:0]                       base_address,
  input  logic [$clog2(DEPTH):0]                         count,
  output logic                                           mem_rdreq,
  output logic [$clog2(DEPTH/WEIGHTMEM_CLK_DIV)-1:0]     mem_rdaddress,
  input  PGP2                                            mem_q,
  output PGP                                             q,
  output logic                                           q_valid,
  input  logic                                           q_ready,
  output logic                                           busy,
  output logic                                           done
);
  localparam int AW = $clog2(DEPTH);
  localparam int WAW = $clog2(DEPTH/WEIGHTMEM_CLK_DIV);
  localparam int CW = $clog2(BUFDEPTH) + 2;
  state_t state, state_nx;
  logic [WAW-1:0] rdaddr;
  logic [AW:0] remaining, words_left;
  logic [AW+1:0] wsum;
  logic parity, zero_done, launch, fire, last, pop;
  logic [RDLAT-1:0] dly;
  logic [CW-1:0] inflight;
  logic [$clog2(BUFDEPTH):0] fcount;
  logic empty;
  PGP2 head;
  assign launch = state == IDLE & start & count != '0;
  assign wsum = {1'b0, count} + (AW+2)'(base_address[0]) + (AW+2)'(1);
  assign fire = q_valid & q_ready;
  assign last = fire & remaining == (AW+1)'(1);
  // the second half of a word is always the last use of it, as is the final element of the burst
  assign pop = fire & (parity | remaining == (AW+1)'(1));
  assign mem_rdreq = state == ISSUE & words_left != '0 & (inflight + CW'(fcount)) < CW'(BUFDEPTH);
  assign mem_rdaddress = rdaddr;
  assign q_valid = !empty & remaining != '0;
  assign q = parity ? head[$bits(PGP)-1:0] : head[$bits(PGP2)-1:$bits(PGP)];
  assign busy = state != IDLE;
  assign done = zero_done | last;
  always_comb
    state_nx = launch ? ISSUE :
               last ? IDLE :
               (state == ISSUE && mem_rdreq && words_left == (AW+1)'(1)) ? DRAIN : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdaddr <= '0;
      remaining <= '0;
      words_left <= '0;
      parity <= 1'b0;
      zero_done <= 1'b0;
      dly <= '0;
      inflight <= '0;
    end else begin
      state <= state_nx;
      zero_done <= state == IDLE & start & count == '0;
      dly <= RDLAT'({dly, mem_rdreq});
      inflight <= inflight + CW'(mem_rdreq) - CW'(dly[RDLAT-1]);
      if (launch) begin
        rdaddr <= base_address[AW-1:1];
        parity <= base_address[0];
        remaining <= count;
        words_left <= wsum[AW+1:1];
      end else begin
        if (mem_rdreq) begin
          rdaddr <= rdaddr == WAW'(DEPTH/WEIGHTMEM_CLK_DIV-1) ? '0 : rdaddr + WAW'(1);
          words_left <= words_left - (AW+1)'(1);
        end
        if (fire) begin
          remaining <= remaining - (AW+1)'(1);
          parity <= ~parity;
        end
      end
    end
  end
  pgpmem_rdunpack_fifo #(.Q(PGP2), .DEPTH(BUFDEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .wr(dly[RDLAT-1]),
    .d(mem_q),
    .rd(pop),
    .q(head),
    .empty(empty),
    .count(fcount)
  );
endmodule

// File: tb/tb_pgpmem_rdunpack.sv
// tb_pgpmem_rdunpack: directed bursts against an SPRAM model, scoreboarded element stream
module tb_pgpmem_rdunpack;
  import pgpmem_rdunpack_pkg::*;
  logic clk = 0, reset = 1, start = 0, q_ready = 1;
  logic [11:0] base_address = '0;
  logic [12:0] count = '0;
  logic mem_rdreq, q_valid, busy, done;
  logic [10:0] mem_rdaddress;
  PGP2 mem_q;
  PGP q;
  logic [10:0] ra0, ra1;
  int checks = 0, errors = 0, cyc = 0;
  int n_req, n_acc, n_done, first_acc, last_acc, done_cyc, start_cyc, max_out, fo;
  logic [15:0] exp_q[$];
  int addr_q[$];
  bit held = 0;
  PGP held_q;

  pgpmem_rdunpack dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address), .count(count),
    .mem_rdreq(mem_rdreq), .mem_rdaddress(mem_rdaddress), .mem_q(mem_q),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] elem(input logic [11:0] e);
    return {4'hA, e};
  endfunction

  function automatic logic [31:0] word(input logic [10:0] w);
    return {elem({w, 1'b0}), elem({w, 1'b1})};
  endfunction

  // two-cycle SPRAM: data for the address requested two cycles ago
  always @(posedge clk) begin
    ra0 <= mem_rdaddress;
    ra1 <= ra0;
  end
  assign mem_q = word(ra1);

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset) held = 0;
    else begin
      if (held) begin
        chk("hold_valid", q_valid, 1);
        chk("hold_q", q, held_q);
      end
      held = q_valid && !q_ready;
      held_q = q;
      if (q_valid && q_ready) begin
        if (exp_q.size() == 0) chk("unexpected_q", q, 32'hdead);
        else chk("q", q, exp_q.pop_front());
        n_acc++;
        if (n_acc == 1) first_acc = cyc;
        last_acc = cyc;
      end
      if (mem_rdreq) begin
        n_req++;
        addr_q.push_back(int'(mem_rdaddress));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (n_req - (fo + n_acc) / 2 > max_out) max_out = n_req - (fo + n_acc) / 2;
    end
  end

  task automatic clear_stats(input int b);
    n_req = 0; n_acc = 0; n_done = 0; max_out = 0; fo = b & 1;
    addr_q.delete();
  endtask

  task automatic go(input int b, input int c, input bit rnd, input bit poke);
    int n = 0;
    clear_stats(b);
    @(posedge clk); #1;
    start = 1; base_address = 12'(b); count = 13'(c); start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    while (n_done == 0 && n < 3000) begin
      start = poke && n == 2;
      if (poke && n == 2) begin base_address = 12'd50; count = 13'd3; end
      if (rnd) q_ready = $urandom_range(0, 9) < 3;
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    q_ready = 1;
    chk("done_seen", n_done != 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("one_done", n_done, 1);
  endtask

  initial begin
    clear_stats(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdreq", mem_rdreq, 0);
    chk("rst_addr", mem_rdaddress, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;

    for (int i = 0; i < 8; i++) exp_q.push_back(16'hA000 + 16'(i));
    go(0, 8, 0, 0);
    chk("aligned_reqs", n_req, 4);
    chk("aligned_latency", first_acc - start_cyc, 4);
    chk("aligned_rate", last_acc - first_acc, 7);
    chk("aligned_done_on_last", done_cyc, last_acc);

    exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
    exp_q.push_back(16'hA005); exp_q.push_back(16'hA006);
    go(3, 4, 0, 0);
    chk("odd_reqs", addr_q.size(), 3);
    for (int i = 0; i < 3 && i < addr_q.size(); i++) chk("odd_addr", addr_q[i], i + 1);

    for (int i = 100; i < 164; i++) exp_q.push_back(16'hA000 + 16'(i));
    go(100, 64, 1, 0);
    chk("bp_reqs", n_req, 32);
    chk("bp_credit", max_out <= 16, 1);
    chk("bp_count", n_acc, 64);

    exp_q.push_back(16'hAFFE); exp_q.push_back(16'hAFFF);
    exp_q.push_back(16'hA000); exp_q.push_back(16'hA001);
    go(4094, 4, 0, 0);
    chk("wrap_reqs", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("wrap_addr0", addr_q[0], 2047);
      chk("wrap_addr1", addr_q[1], 0);
    end

    for (int i = 0; i < 8; i++) exp_q.push_back(16'hA000 + 16'(i));
    go(0, 8, 0, 1);
    chk("busy_start_reqs", n_req, 4);
    chk("busy_start_acc", n_acc, 8);

    clear_stats(0);
    @(posedge clk); #1;
    start = 1; base_address = 12'd5; count = 13'd0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_once", done, 0);
    chk("zero_reqs", n_req, 0);
    chk("zero_done_count", n_done, 1);

    clear_stats(0);
    @(posedge clk); #1;
    start = 1; base_address = 12'd10; count = 13'd20;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rdreq", mem_rdreq, 0);
    chk("abort_addr", mem_rdaddress, 0);
    chk("abort_valid", q_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_no_q", n_acc, 0);

    for (int i = 8; i < 12; i++) exp_q.push_back(16'hA000 + 16'(i));
    go(8, 4, 0, 0);
    chk("post_abort_reqs", n_req, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pgpmem_rdunpack.md
PGPMEM_RDUNPACK -- requirements
Module: pgpmem_rdunpack

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4096, memory depth in PGP elements; RDLAT, default 2, fixed SPRAM read latency in cycles; BUFDEPTH, default 16, wide-word buffer entries.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a burst.
- base_address  in  $clog2(DEPTH)  first PGP element address.
- count  in  $clog2(DEPTH)+1  number of PGP elements in the burst; 0 means no-op.
- mem_rdreq  out  1  wide-word read strobe to the SPRAM.
- mem_rdaddress  out  $clog2(DEPTH/WEIGHTMEM_CLK_DIV)  wide-word read address.
- mem_q  in  $bits(PGP2)  read data, valid exactly RDLAT cycles after mem_rdreq.
- q  out  $bits(PGP)  unpacked element.
- q_valid  out  1  q is valid.
- q_ready  in  1  downstream accepts q.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on acceptance of the last element.

Function
REQ-003 The block SHALL be the read-side counterpart of the weight-memory write packer: each PGP2 word holds WEIGHTMEM_CLK_DIV=2 elements, and the even-address element occupies the upper half of the word.
REQ-004 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-005 In IDLE, start with count!=0 SHALL latch rdaddr=base_address>>1, first_odd=base_address[0] and remaining=count, then move to ISSUE; start with count==0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-006 A start pulse in ISSUE or DRAIN SHALL be ignored.
REQ-007 The number of wide words to read SHALL be ceil((base_address[0]+count)/2), held in a words_left counter.
REQ-008 In ISSUE, mem_rdreq SHALL assert on any cycle where words_left!=0 and inflight+buffered<BUFDEPTH; this credit rule is what prevents buffer overflow.
REQ-009 Each mem_rdreq SHALL increment rdaddr, wrapping from DEPTH/2-1 to 0.
REQ-010 When words_left reaches 0 the FSM SHALL move from ISSUE to DRAIN.
REQ-011 A valid-delay shift register RDLAT deep SHALL write mem_q into the wide-word buffer exactly RDLAT cycles after each mem_rdreq.
REQ-012 The unpacker SHALL hold a parity bit, initialised to first_odd; q SHALL be the upper half of the buffer head when parity=0 and the lower half when parity=1.
REQ-013 q_valid SHALL equal !buffer_empty & remaining!=0; q SHALL be combinational from the buffer head and parity.
REQ-014 On q_valid & q_ready: remaining SHALL decrement and parity SHALL toggle; the buffer SHALL pop when parity==1 or remaining==1, so the leftover half of an odd-ended burst is discarded.
REQ-015 When the last element is accepted, done SHALL pulse and the FSM SHALL return to IDLE on the next cycle.
REQ-016 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE.
REQ-017 When q_ready is held low, q and q_valid SHALL remain stable, and issue SHALL stall once the credit limit is reached.
REQ-018 The sustained rate SHALL be one element per cycle with q_ready high; first-element latency SHALL be RDLAT+2 cycles after start.

Reset
REQ-019 While reset is high, the FSM SHALL enter IDLE and the buffer, delay line, counters, inflight and parity SHALL be cleared.
REQ-020 Outputs SHALL reset to mem_rdreq=0, mem_rdaddress=0, q_valid=0, busy=0, done=0; q is don't-care.
REQ-021 A reset asserted mid-burst SHALL abort the burst: no done pulse, and SPRAM data returning after reset SHALL be dropped.

Structure
REQ-022 PGP, PGP2 and WEIGHTMEM_CLK_DIV SHALL come from package globals; no new package types are required.
REQ-023 The wide-word buffer SHALL instantiate the existing fifo sub-module (Q=PGP2, DEPTH=BUFDEPTH).
REQ-024 The credit counter and delay line SHALL be local logic.

Verification
REQ-025 Aligned burst: memory words 0..3 = {A1,A0},{B1,B0},... in {upper,lower} order; base=0, count=8, q_ready=1 -> q = A1,A0,B1,B0,C1,C0,D1,D0 on consecutive cycles, done pulses on D0, exactly 4 mem_rdreq issued.
REQ-026 Odd start and end: base=3, count=4 -> reads of words 1,2,3; q = B0,C1,C0,D1; D0 is discarded; done pulses once.
REQ-027 Backpressure: count=64 with q_ready toggling at random (about 30% high) -> all 64 elements in order, no buffer overflow, inflight+buffered never exceeds 16.
REQ-028 Wrap-around: DEPTH=4096, base=4094, count=4 -> mem_rdaddress sequence 2047 then 0; q = elements 4094,4095,0,1.
REQ-029 Control corners: start while busy is ignored; count=0 gives done one cycle after start with no mem_rdreq; reset asserted mid-burst gives outputs at reset values next cycle and no done.
